// File: rtl/byte_ser_tx.sv
// byte_ser_tx: byte FIFO feeding an MSB-first serialiser with sof/last framing strobes.
// Define SER_PARITY_EN to append an even-parity bit to every frame (9-bit frames).
module byte_ser_tx #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    data_in,
  input  logic          data_en,
  input  logic          ovf_clr,
  output logic          ser_o,
  output logic          ser_valid,
  output logic          ser_sof,
  output logic          ser_last,
  output logic [AW:0]   fifo_level,
  output logic          ovf
);

`ifdef SER_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
`endif
  localparam logic [3:0]    PRE_LAST = LAST_BIT - 4'd1;
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    head;
  logic [7:0]    shreg, shreg_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic          ser_valid_n, ser_sof_n, ser_last_n;
  logic          push, drop, pop, fifo_empty;
`ifdef SER_PARITY_EN
  logic          par, par_n;
`endif

  // Full is judged on the registered level only, so a same-edge pop cannot rescue a write.
  assign fifo_empty = (fifo_level == '0);
  assign push       = data_en && (fifo_level != FULL);
  assign drop       = data_en && (fifo_level == FULL);
  assign head       = mem[rd_ptr];
  assign ser_o      = shreg[7];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      fifo_level <= fifo_level + LVL_ONE;
      else if (pop && !push) fifo_level <= fifo_level - LVL_ONE;
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // ser_o is the MSB of the shift register, so clearing it on idle also zeroes the line.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bit_cnt_n   = bit_cnt;
    ser_valid_n = ser_valid;
    ser_sof_n   = ser_sof;
    ser_last_n  = ser_last;
    pop         = 1'b0;
`ifdef SER_PARITY_EN
    par_n       = par;
`endif
    if ((state == IDLE) || (bit_cnt == LAST_BIT)) begin
      if (!fifo_empty) begin
        pop         = 1'b1;
        state_n     = SHIFT;
        shreg_n     = head;
        bit_cnt_n   = 4'd0;
        ser_valid_n = 1'b1;
        ser_sof_n   = 1'b1;
        ser_last_n  = 1'b0;
`ifdef SER_PARITY_EN
        par_n       = ^head;
`endif
      end else begin
        state_n     = IDLE;
        shreg_n     = 8'd0;
        bit_cnt_n   = 4'd0;
        ser_valid_n = 1'b0;
        ser_sof_n   = 1'b0;
        ser_last_n  = 1'b0;
      end
    end else begin
      bit_cnt_n  = bit_cnt + 4'd1;
      ser_sof_n  = 1'b0;
      ser_last_n = (bit_cnt == PRE_LAST);
`ifdef SER_PARITY_EN
      if (bit_cnt == 4'd7) shreg_n = {par, 7'd0};
      else                 shreg_n = {shreg[6:0], 1'b0};
`else
      shreg_n = {shreg[6:0], 1'b0};
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= 8'd0;
      bit_cnt   <= 4'd0;
      ser_valid <= 1'b0;
      ser_sof   <= 1'b0;
      ser_last  <= 1'b0;
`ifdef SER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      ser_valid <= ser_valid_n;
      ser_sof   <= ser_sof_n;
      ser_last  <= ser_last_n;
`ifdef SER_PARITY_EN
      par       <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_byte_ser_tx.sv
// tb_byte_ser_tx: directed bench for byte_ser_tx with a queue-based frame model checked every cycle.
// Honours SER_PARITY_EN so the same bench covers both frame lengths.
module tb_byte_ser_tx;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef SER_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    data_in;
  logic          data_en;
  logic          ovf_clr;
  logic          ser_o, ser_valid, ser_sof, ser_last, ovf;
  logic [AW:0]   fifo_level;

  int vectors     = 0;
  int miscompares = 0;

  byte_ser_tx #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_en(data_en), .ovf_clr(ovf_clr),
    .ser_o(ser_o), .ser_valid(ser_valid), .ser_sof(ser_sof), .ser_last(ser_last),
    .fifo_level(fifo_level), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Model: a byte queue plus the frame currently on the wire and the position within it.
  logic [7:0] mq[$];
  logic [0:8] m_frame = '0;
  int         m_pos   = -1;
  logic       m_ovf   = 1'b0;
  int         m_sz;
  logic       cap_q[$];

  function automatic logic [0:8] make_frame(input logic [7:0] b);
    logic [0:8] f;
    for (int i = 0; i < 8; i++) f[i] = b[7-i];
    f[8] = ^b;
    return f;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_pos   = -1;
      m_ovf   = 1'b0;
      m_frame = '0;
    end else begin
      m_sz = mq.size();
      if (m_pos < 0 || m_pos == FLEN-1) begin
        if (m_sz > 0) begin
          m_frame = make_frame(mq.pop_front());
          m_pos   = 0;
        end else begin
          m_pos = -1;
        end
      end else begin
        m_pos++;
      end
      if (data_en && m_sz >= DEPTH) m_ovf = 1'b1;
      else if (ovf_clr)             m_ovf = 1'b0;
      if (data_en && m_sz < DEPTH) mq.push_back(data_in);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("ser_valid", 64'(ser_valid), 64'(m_pos >= 0));
    checkOutput("ser_o", 64'(ser_o), 64'((m_pos >= 0) ? m_frame[m_pos] : 1'b0));
    checkOutput("ser_sof", 64'(ser_sof), 64'(m_pos == 0));
    checkOutput("ser_last", 64'(ser_last), 64'(m_pos == FLEN-1));
    checkOutput("fifo_level", 64'(fifo_level), 64'(mq.size()));
    checkOutput("ovf", 64'(ovf), 64'(m_ovf));
    if (ser_valid === 1'b1) cap_q.push_back(ser_o);
  end

  function automatic logic [63:0] cap_bits(input int first, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[62:0], cap_q[first+i]};
    return v;
  endfunction

  // Inputs change just after a falling edge; returns just after the next falling edge.
  task automatic applyStimulus(input logic en, input logic [7:0] d, input logic clr);
    data_en = en;
    data_in = d;
    ovf_clr = clr;
    @(posedge clk);
    @(negedge clk);
    #1;
    data_en = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic doReset();
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    cap_q.delete();
  endtask

  initial begin
    reset   = 1'b0;
    data_en = 1'b0;
    data_in = 8'h00;
    ovf_clr = 1'b0;
    doReset();
    checkOutput("reset_valid", 64'(ser_valid), 64'd0);
    checkOutput("reset_level", 64'(fifo_level), 64'd0);
    checkOutput("reset_ovf", 64'(ovf), 64'd0);

    $display("[TB] single byte 0xA5");
    applyStimulus(1'b1, 8'hA5, 1'b0);
    checkOutput("t1_level_N", 64'(fifo_level), 64'd1);
    checkOutput("t1_valid_N", 64'(ser_valid), 64'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t1_level_N1", 64'(fifo_level), 64'd0);
    checkOutput("t1_sof", 64'(ser_sof), 64'd1);
    checkOutput("t1_msb", 64'(ser_o), 64'd1);
    idle(FLEN-1);
    checkOutput("t1_last", 64'(ser_last), 64'd1);
    idle(3);
    checkOutput("t1_bits_n", 64'(cap_q.size()), 64'(FLEN));
`ifdef SER_PARITY_EN
    checkOutput("t1_bits", cap_bits(0, FLEN), 64'({8'hA5, 1'b0}));
`else
    checkOutput("t1_bits", cap_bits(0, FLEN), 64'(8'hA5));
`endif
    checkOutput("t1_ovf", 64'(ovf), 64'd0);

    $display("[TB] back-to-back 0x87 0x69");
    doReset();
    applyStimulus(1'b1, 8'h87, 1'b0);
    applyStimulus(1'b1, 8'h69, 1'b0);
    idle(2*FLEN + 3);
    checkOutput("t2_bits_n", 64'(cap_q.size()), 64'(2*FLEN));
`ifdef SER_PARITY_EN
    checkOutput("t2_bits", cap_bits(0, 2*FLEN), 64'({8'h87, 1'b0, 8'h69, 1'b0}));
`else
    checkOutput("t2_bits", cap_bits(0, 2*FLEN), 64'(16'h8769));
`endif

    $display("[TB] overflow burst 0x00..0x09");
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      if (i == 8) checkOutput("t3_level_full", 64'(fifo_level), 64'd8);
      if (i == 8) checkOutput("t3_ovf_before", 64'(ovf), 64'd0);
    end
    checkOutput("t3_ovf_set", 64'(ovf), 64'd1);
    idle(9*FLEN + 5);
    checkOutput("t3_bits_n", 64'(cap_q.size()), 64'(9*FLEN));
    checkOutput("t3_first", cap_bits(0, 8), 64'(8'h00));
    checkOutput("t3_last_byte", cap_bits(8*FLEN, 8), 64'(8'h08));
    checkOutput("t3_ovf_held", 64'(ovf), 64'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t3_ovf_clr", 64'(ovf), 64'd0);

    $display("[TB] reset mid-byte");
    doReset();
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h0F, 1'b0);
    idle(3);
    checkOutput("t4_pre_o", 64'(ser_o), 64'd1);
    checkOutput("t4_pre_level", 64'(fifo_level), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("t4_async_valid", 64'(ser_valid), 64'd0);
    checkOutput("t4_async_o", 64'(ser_o), 64'd0);
    checkOutput("t4_async_level", 64'(fifo_level), 64'd0);
    checkOutput("t4_async_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    cap_q.delete();
    idle(20);
    checkOutput("t4_no_residue", 64'(cap_q.size()), 64'd0);

`ifdef SER_PARITY_EN
    $display("[TB] parity 0x07 0x03");
    doReset();
    applyStimulus(1'b1, 8'h07, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b0);
    idle(8);
    checkOutput("t5_par_last", 64'(ser_last), 64'd1);
    checkOutput("t5_par_bit", 64'(ser_o), 64'd1);
    idle(FLEN + 3);
    checkOutput("t5_bits", cap_bits(0, 18), 64'({8'h07, 1'b1, 8'h03, 1'b0}));
`endif

    $display("[TB] write on the final-bit edge");
    doReset();
    applyStimulus(1'b1, 8'hA5, 1'b0);
    idle(FLEN);
    checkOutput("t6_last", 64'(ser_last), 64'd1);
    applyStimulus(1'b1, 8'h3C, 1'b0);
    checkOutput("t6_gap_valid", 64'(ser_valid), 64'd0);
    checkOutput("t6_gap_level", 64'(fifo_level), 64'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t6_resume_valid", 64'(ser_valid), 64'd1);
    checkOutput("t6_resume_sof", 64'(ser_sof), 64'd1);
    idle(FLEN + 2);
    checkOutput("t6_second", cap_bits(FLEN, 8), 64'(8'h3C));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
